// File: rtl/spiflash_pkg.sv
// Shared types and constants for the single-IO SPI flash read controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spiflash_pkg;

  // Controller sequencing states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DONE,
    ST_CSWAIT
  } state_e;

  // Standard single-IO read opcode
  localparam logic [7:0] SPI_CMD_READ = 8'h03;

  // Bits shifted in each transaction phase
  localparam logic [5:0] CMD_BITS  = 6'd8;
  localparam logic [5:0] ADDR_BITS = 6'd24;
  localparam logic [5:0] DATA_BITS = 6'd32;

  // The flash returns the lowest-addressed byte first; the fetch port wants it in bits [7:0]
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spiflash_bit_engine.sv
// SPI mode-0 bit engine: shifts nbits out on MOSI (MSB first) while shifting MISO into rx.
// Latency: 2*CLK_DIV clk cycles per bit; done_o is high in the last cycle of the final SCK-high phase.
// Backpressure: none; a start_i coinciding with done_o chains the next phase with no idle cycle.
module spiflash_bit_engine #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        start_i,
  input  logic [5:0]  nbits_i,
  input  logic [31:0] tx_i,
  input  logic        miso_i,
  output logic        done_o,
  output logic        sck_o,
  output logic        mosi_o,
  output logic [31:0] rx_o
);

  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic            busy_q;
  logic            sck_q;
  logic            mosi_q;
  logic [DIVW-1:0] div_q;
  logic [5:0]      bits_q;
  logic [31:0]     tx_q;
  logic [31:0]     rx_q;
  logic            half_end;

  assign half_end = (div_q == DIVW'(CLK_DIV - 1));
  assign done_o   = busy_q && sck_q && half_end && (bits_q == 6'd1);
  assign sck_o    = sck_q;
  assign mosi_o   = mosi_q;
  assign rx_o     = rx_q;

  // Half-period divider, SCK toggling, MOSI launch at low-phase start and MISO capture on SCK rise
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      busy_q <= 1'b0;
      sck_q  <= 1'b0;
      mosi_q <= 1'b0;
      div_q  <= '0;
      bits_q <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      sck_q  <= 1'b0;
      div_q  <= '0;
      bits_q <= nbits_i;
      mosi_q <= tx_i[31];
      tx_q   <= {tx_i[30:0], 1'b0};
    end else if (busy_q) begin
      if (half_end) begin
        div_q <= '0;
        if (!sck_q) begin
          sck_q <= 1'b1;
          rx_q  <= {rx_q[30:0], miso_i};
        end else begin
          sck_q <= 1'b0;
          if (bits_q == 6'd1) begin
            busy_q <= 1'b0;
          end else begin
            bits_q <= bits_q - 6'd1;
            mosi_q <= tx_q[31];
            tx_q   <= {tx_q[30:0], 1'b0};
          end
        end
      end else begin
        div_q <= div_q + DIVW'(1);
      end
    end
  end

endmodule

// File: rtl/spiflash_rd_ctrl.sv
// Word-read SPI flash controller: 0x03 READ per request, optional sequential continuation with CSB held low.
// Latency: 1+128*CLK_DIV cycles full path, 1+64*CLK_DIV continuation, +CSB_HIGH+1 when CSB must be cycled.
// Backpressure: requester holds valid/addr until the one-cycle ready pulse; requests are ignored outside IDLE.
module spiflash_rd_ctrl
  import spiflash_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int CSB_HIGH  = 2,
  parameter int CONT_READ = 1
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        valid,
  input  logic [23:0] addr,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1
);

  localparam int CSW = (CSB_HIGH > 1) ? $clog2(CSB_HIGH) : 1;

  state_e         state_q;
  logic           csb_q;
  logic           ready_q;
  logic [31:0]    rdata_q;
  logic [23:0]    addr_q;
  logic [23:0]    last_addr_q;
  logic           last_vld_q;
  logic [CSW-1:0] csw_cnt_q;

  logic [23:0]    addr_al;
  logic           seq_hit;
  logic           eng_start;
  logic [5:0]     eng_nbits;
  logic [31:0]    eng_tx;
  logic           eng_done;
  logic [31:0]    eng_rx;
  logic           unused_addr_lsb;

  assign unused_addr_lsb = ^addr[1:0];
  assign addr_al = {addr[23:2], 2'b00};

  // Continuation only while the flash is still streaming from the word just returned
  assign seq_hit = (CONT_READ != 0) && !csb_q && last_vld_q &&
                   (addr_al == (last_addr_q + 24'd4));

  // Phase launch: kick the engine on acceptance and on each phase boundary so phases abut
  always_comb begin
    eng_start = 1'b0;
    eng_nbits = CMD_BITS;
    eng_tx    = '0;
    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          if (seq_hit) begin
            eng_start = 1'b1;
            eng_nbits = DATA_BITS;
          end else if (csb_q) begin
            eng_start = 1'b1;
            eng_nbits = CMD_BITS;
            eng_tx    = {SPI_CMD_READ, 24'h000000};
          end
        end
      end
      ST_CMD: begin
        if (eng_done) begin
          eng_start = 1'b1;
          eng_nbits = ADDR_BITS;
          eng_tx    = {addr_q, 8'h00};
        end
      end
      ST_ADDR: begin
        if (eng_done) begin
          eng_start = 1'b1;
          eng_nbits = DATA_BITS;
        end
      end
      default: ;
    endcase
  end

  // Transaction sequencing, chip select, address tracking and the registered read response
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= ST_IDLE;
      csb_q       <= 1'b1;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      addr_q      <= '0;
      last_addr_q <= '0;
      last_vld_q  <= 1'b0;
      csw_cnt_q   <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (valid) begin
            if (seq_hit) begin
              addr_q  <= addr_al;
              state_q <= ST_DATA;
            end else if (!csb_q) begin
              csb_q     <= 1'b1;
              csw_cnt_q <= '0;
              state_q   <= ST_CSWAIT;
            end else begin
              addr_q  <= addr_al;
              csb_q   <= 1'b0;
              state_q <= ST_CMD;
            end
          end
        end
        ST_CMD: begin
          if (eng_done) state_q <= ST_ADDR;
        end
        ST_ADDR: begin
          if (eng_done) state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (eng_done) begin
            state_q <= ST_DONE;
            ready_q <= 1'b1;
            rdata_q <= bswap32(eng_rx);
            if (CONT_READ == 0) csb_q <= 1'b1;
          end
        end
        ST_DONE: begin
          last_addr_q <= addr_q;
          last_vld_q  <= 1'b1;
          if (CONT_READ != 0) begin
            state_q <= ST_IDLE;
          end else begin
            csw_cnt_q <= '0;
            state_q   <= ST_CSWAIT;
          end
        end
        ST_CSWAIT: begin
          if (csw_cnt_q == CSW'(CSB_HIGH - 1)) state_q <= ST_IDLE;
          else csw_cnt_q <= csw_cnt_q + CSW'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  spiflash_bit_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_engine (
    .clk     (clk),
    .resetb  (resetb),
    .start_i (eng_start),
    .nbits_i (eng_nbits),
    .tx_i    (eng_tx),
    .miso_i  (flash_io1),
    .done_o  (eng_done),
    .sck_o   (flash_clk),
    .mosi_o  (flash_io0),
    .rx_o    (eng_rx)
  );

  assign flash_csb = csb_q;
  assign ready     = ready_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_spiflash_rd_ctrl.sv
// Directed bench: two controllers (continuation on, CSB_HIGH=2; continuation off, CSB_HIGH=4) each on a flash model.
// Latency is counted in clk edges from the first edge that sees valid to the edge where ready is seen.
// Flash model answers 0x03 reads, streams sequential bytes while CSB stays low.
module tb_spiflash_rd_ctrl;

  logic        clk = 1'b0;
  logic        resetb = 1'b1;
  logic        valid_a = 1'b0;
  logic        valid_b = 1'b0;
  logic [23:0] addr_a = '0;
  logic [23:0] addr_b = '0;
  logic        ready_a, ready_b;
  logic [31:0] rdata_a, rdata_b;
  logic [1:0]  csb_w, sck_w, mosi_w, miso_w;
  logic [7:0]  mem [1024];
  int          total = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  spiflash_rd_ctrl #(.CLK_DIV(2), .CSB_HIGH(2), .CONT_READ(1)) u_a (
    .clk(clk), .resetb(resetb), .valid(valid_a), .addr(addr_a),
    .ready(ready_a), .rdata(rdata_a),
    .flash_csb(csb_w[0]), .flash_clk(sck_w[0]), .flash_io0(mosi_w[0]), .flash_io1(miso_w[0])
  );

  spiflash_rd_ctrl #(.CLK_DIV(2), .CSB_HIGH(4), .CONT_READ(0)) u_b (
    .clk(clk), .resetb(resetb), .valid(valid_b), .addr(addr_b),
    .ready(ready_b), .rdata(rdata_b),
    .flash_csb(csb_w[1]), .flash_clk(sck_w[1]), .flash_io0(mosi_w[1]), .flash_io1(miso_w[1])
  );

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[0] = 8'h11;
    mem[1] = 8'h22;
    mem[2] = 8'h33;
    mem[3] = 8'h44;
  end

  for (genvar g = 0; g < 2; g++) begin : g_fl
    int          bits = 0;
    int          ncmd = 0;
    int          d;
    logic [31:0] sh = '0;
    logic [7:0]  cmd = '0;
    logic [23:0] fa = '0;
    logic [7:0]  b;
    logic        miso_r = 1'b0;
    int          hi_run = 0;
    int          last_hi = 0;
    int          rises = 0;
    int          viol = 0;
    logic        csb_p = 1'b1;

    assign miso_w[g] = miso_r;

    always @(negedge csb_w[g]) bits = 0;

    always @(posedge sck_w[g]) begin
      if (csb_w[g] == 1'b0) begin
        if (bits < 32) sh = {sh[30:0], mosi_w[g]};
        bits = bits + 1;
        if (bits == 32) begin
          cmd  = sh[31:24];
          fa   = sh[23:0];
          ncmd = ncmd + 1;
        end
        if (bits >= 32) begin
          d      = bits - 32;
          b      = mem[10'(fa) + 10'(d / 8)];
          miso_r = b[7 - (d % 8)];
        end
      end
    end

    always @(negedge clk) begin
      if (csb_w[g] !== csb_p) begin
        if (sck_w[g] !== 1'b0) viol = viol + 1;
        if (csb_w[g] === 1'b1) rises = rises + 1;
        else last_hi = hi_run;
      end
      if (csb_w[g] === 1'b1) hi_run = hi_run + 1;
      else hi_run = 0;
      csb_p = csb_w[g];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic rd(input int ch, input logic [23:0] a, output logic [31:0] dat, output int lat);
    bit seen;
    seen = 1'b0;
    dat  = '0;
    lat  = 0;
    @(negedge clk);
    if (ch == 0) begin valid_a = 1'b1; addr_a = a; end
    else begin valid_b = 1'b1; addr_b = a; end
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if ((ch == 0) ? ready_a : ready_b) begin
        seen = 1'b1;
        dat  = (ch == 0) ? rdata_a : rdata_b;
      end
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
    if (!seen) lat = -1;
  endtask

  initial begin
    logic [31:0] dat;
    int          lat;
    int          n0;
    int          r0;

    #1 resetb = 1'b0;
    #1;
    chk("rst_csb",   32'(csb_w[0]), 32'd1);
    chk("rst_sck",   32'(sck_w[0]), 32'd0);
    chk("rst_io0",   32'(mosi_w[0]), 32'd0);
    chk("rst_ready", 32'(ready_a), 32'd0);
    chk("rst_rdata", rdata_a, 32'h0);
    repeat (3) @(negedge clk);
    resetb = 1'b1;

    // Full path read from reset
    rd(0, 24'h000000, dat, lat);
    chk("full_data", dat, 32'h44332211);
    chk("full_lat", 32'(lat), 32'd257);
    chk("full_cmd", 32'(g_fl[0].cmd), 32'h03);
    chk("full_addr", 32'(g_fl[0].fa), 32'h000000);
    @(negedge clk);
    chk("ready_pulse", 32'(ready_a), 32'd0);

    // Sequential continuation: no command, CSB stays low
    n0 = g_fl[0].ncmd;
    r0 = g_fl[0].rises;
    rd(0, 24'h000004, dat, lat);
    chk("cont_data", dat, 32'hA2A3A0A1);
    chk("cont_lat", 32'(lat), 32'd129);
    chk("cont_nocmd", 32'(g_fl[0].ncmd), 32'(n0));
    chk("cont_csb_low", 32'(g_fl[0].rises), 32'(r0));

    // Non-sequential with CSB low: CSB cycled, full command resent
    rd(0, 24'h000100, dat, lat);
    chk("jump_data", dat, 32'hA6A7A4A5);
    chk("jump_lat", 32'(lat), 32'd260);
    chk("jump_cmd", 32'(g_fl[0].cmd), 32'h03);
    chk("jump_addr", 32'(g_fl[0].fa), 32'h000100);
    chk("jump_csb_hi", 32'(g_fl[0].last_hi >= 2), 32'd1);
    chk("jump_recmd", 32'(g_fl[0].ncmd), 32'(n0 + 1));

    // Unaligned request is word-aligned on the wire
    rd(0, 24'h000007, dat, lat);
    chk("unal_addr", 32'(g_fl[0].fa), 32'h000004);
    chk("unal_data", dat, 32'hA2A3A0A1);
    chk("unal_lat", 32'(lat), 32'd260);

    // Asynchronous reset during the address phase
    @(negedge clk);
    valid_a = 1'b1;
    addr_a  = 24'h000000;
    repeat (60) @(negedge clk);
    #2 resetb = 1'b0;
    #1;
    chk("arst_csb", 32'(csb_w[0]), 32'd1);
    chk("arst_sck", 32'(sck_w[0]), 32'd0);
    chk("arst_ready", 32'(ready_a), 32'd0);
    valid_a = 1'b0;
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    n0 = g_fl[0].ncmd;
    rd(0, 24'h000000, dat, lat);
    chk("post_rst_data", dat, 32'h44332211);
    chk("post_rst_lat", 32'(lat), 32'd257);
    chk("post_rst_cmd", 32'(g_fl[0].ncmd), 32'(n0 + 1));

    // Top-of-array word, then continuation wrapping to address 0
    rd(0, 24'hFFFFFC, dat, lat);
    chk("top_data", dat, 32'h5A5B5859);
    chk("top_lat", 32'(lat), 32'd260);
    chk("top_addr", 32'(g_fl[0].fa), 32'hFFFFFC);
    n0 = g_fl[0].ncmd;
    rd(0, 24'h000000, dat, lat);
    chk("wrap_data", dat, 32'h44332211);
    chk("wrap_lat", 32'(lat), 32'd129);
    chk("wrap_nocmd", 32'(g_fl[0].ncmd), 32'(n0));

    // Continuation disabled: every read is full path with a CSB-high gap
    rd(1, 24'h000008, dat, lat);
    chk("b1_data", dat, 32'hAEAFACAD);
    chk("b1_lat", 32'(lat), 32'd257);
    chk("b1_csb_done", 32'(csb_w[1]), 32'd1);
    rd(1, 24'h00000C, dat, lat);
    chk("b2_data", dat, 32'hAAABA8A9);
    chk("b2_lat", 32'(lat), 32'd261);
    chk("b2_addr", 32'(g_fl[1].fa), 32'h00000C);
    chk("b_ncmd", 32'(g_fl[1].ncmd), 32'd2);
    chk("b_csb_hi", 32'(g_fl[1].last_hi >= 4), 32'd1);

    // SCK must be low at every CSB edge on both buses
    chk("sck_at_csb_a", 32'(g_fl[0].viol), 32'd0);
    chk("sck_at_csb_b", 32'(g_fl[1].viol), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
